// File: rtl/bit_scrambler_packer.sv
// Byte-stream 802.11 scrambler (x^7 + x^4 + 1) and 4:1 byte packer.
// Feeds 32-bit words (first byte in LSBs) to the modulator FIFO.
//
// Ports:
//   clk        - single clock
//   rst        - asynchronous active-low reset
//   reset_mod  - synchronous clear, same effect as rst
//   s_tdata    - input byte          s_tvalid/s_tready/s_tlast - input handshake
//   m_tdata    - packed word         m_tvalid/m_tready/m_tlast - output handshake
module bit_scrambler_packer #(
    parameter int         C_S_AXIS_TDATA_WIDTH = 8,
    parameter int         C_M_AXIS_TDATA_WIDTH = 32,
    parameter logic [6:0] LFSR_SEED            = 7'h7F,
    parameter bit         SCRAMBLE_EN          = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            reset_mod,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_tdata,
    input  logic                            s_tvalid,
    output logic                            s_tready,
    input  logic                            s_tlast,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast
);

    logic [6:0]  lfsr_q, lfsr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] acc_q, acc_d;
    logic [31:0] m_tdata_q, m_tdata_d;
    logic        m_tvalid_q, m_tvalid_d;
    logic        m_tlast_q, m_tlast_d;

    logic [6:0]  lfsr_walk;
    logic [6:0]  lfsr_next;
    logic [7:0]  scr_byte;
    logic        fb;
    logic [31:0] word;
    logic        accept;

    assign s_tready = rst && (!m_tvalid_q || m_tready);
    assign accept   = s_tvalid && s_tready;

    // Eight LFSR steps unrolled, bit 0 first, so one byte per cycle.
    always_comb begin
        lfsr_walk = lfsr_q;
        scr_byte  = '0;
        fb        = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fb          = lfsr_walk[6] ^ lfsr_walk[3];
            scr_byte[i] = s_tdata[i] ^ fb;
            lfsr_walk   = {lfsr_walk[5:0], fb};
        end
        lfsr_next = lfsr_walk;
        if (!SCRAMBLE_EN) begin
            scr_byte  = s_tdata[7:0];
            lfsr_next = lfsr_q;
        end
    end

    // Bytes above byte_cnt are still zero in acc, which gives the
    // zero padding of a word cut short by tlast.
    always_comb begin
        word = {8'h00, acc_q};
        unique case (byte_cnt_q)
            2'd0: word[7:0]   = scr_byte;
            2'd1: word[15:8]  = scr_byte;
            2'd2: word[23:16] = scr_byte;
            2'd3: word[31:24] = scr_byte;
            default: word = {8'h00, acc_q};
        endcase
    end

    always_comb begin
        lfsr_d     = lfsr_q;
        byte_cnt_d = byte_cnt_q;
        acc_d      = acc_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;

        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end

        if (accept) begin
            if (byte_cnt_q == 2'd3 || s_tlast) begin
                m_tdata_d  = word;
                m_tvalid_d = 1'b1;
                m_tlast_d  = s_tlast;
                byte_cnt_d = 2'd0;
                acc_d      = '0;
            end else begin
                acc_d      = word[23:0];
                byte_cnt_d = byte_cnt_q + 2'd1;
            end
            lfsr_d = s_tlast ? LFSR_SEED : lfsr_next;
        end

        // Synchronous clear wins over a byte accepted in the same cycle.
        if (reset_mod) begin
            lfsr_d     = LFSR_SEED;
            byte_cnt_d = 2'd0;
            acc_d      = '0;
            m_tdata_d  = '0;
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q     <= LFSR_SEED;
            byte_cnt_q <= 2'd0;
            acc_q      <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            byte_cnt_q <= byte_cnt_d;
            acc_q      <= acc_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;

endmodule

// File: tb/tb_bit_scrambler_packer.sv
// Directed bench for bit_scrambler_packer: scrambled and bypass
// instances, vector table plus backpressure/reset/stream sequences.
module tb_bit_scrambler_packer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic reset_mod = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  a_s_tdata = '0, b_s_tdata = '0;
    logic        a_s_tvalid = 1'b0, b_s_tvalid = 1'b0;
    logic        a_s_tlast = 1'b0, b_s_tlast = 1'b0;
    logic        a_s_tready, b_s_tready;
    logic [31:0] a_m_tdata, b_m_tdata;
    logic        a_m_tvalid, b_m_tvalid;
    logic        a_m_tlast, b_m_tlast;
    logic        a_m_tready = 1'b1, b_m_tready = 1'b1;

    bit_scrambler_packer u_scr (
        .clk(clk), .rst(rst), .reset_mod(reset_mod),
        .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid),
        .s_tready(a_s_tready), .s_tlast(a_s_tlast),
        .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid),
        .m_tready(a_m_tready), .m_tlast(a_m_tlast)
    );

    bit_scrambler_packer #(.SCRAMBLE_EN(1'b0)) u_byp (
        .clk(clk), .rst(rst), .reset_mod(reset_mod),
        .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid),
        .s_tready(b_s_tready), .s_tlast(b_s_tlast),
        .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid),
        .m_tready(b_m_tready), .m_tlast(b_m_tlast)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // {m_tlast, m_tdata} of every completed output handshake
    logic [32:0] qa[$];
    logic [32:0] qb[$];

    always @(negedge clk) begin
        if (a_m_tvalid && a_m_tready) qa.push_back({a_m_tlast, a_m_tdata});
        if (b_m_tvalid && b_m_tready) qb.push_back({b_m_tlast, b_m_tdata});
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel != 0) ? b_s_tready : a_s_tready;
    endfunction

    function automatic logic [32:0] pop_word(input int sel);
        logic [32:0] w;
        w = '0;
        if (sel == 0 && qa.size() > 0) w = qa.pop_front();
        if (sel != 0 && qb.size() > 0) w = qb.pop_front();
        return w;
    endfunction

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic send(input int sel, input logic [7:0] d,
                        input logic last);
        int t;
        if (sel != 0) begin
            b_s_tdata = d; b_s_tlast = last; b_s_tvalid = 1'b1;
        end else begin
            a_s_tdata = d; a_s_tlast = last; a_s_tvalid = 1'b1;
        end
        t = 0;
        forever begin
            @(negedge clk);
            if (rdy(sel)) break;
            t++;
            if (t > 200) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL send_timeout: sel %0d byte %h", sel, d);
                break;
            end
        end
        @(posedge clk); #2;
        if (sel != 0) begin
            b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
        end else begin
            a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
        end
    endtask

    task automatic pulse_reset_mod();
        reset_mod = 1'b1;
        @(posedge clk); #2;
        reset_mod = 1'b0;
    endtask

    typedef struct {
        int          sel;
        int          n;
        logic [31:0] din;
        logic        last;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    vec_t vt[8];
    logic [32:0] w;
    logic [31:0] held;
    bit done;

    initial begin
        // Expected words from the 802.11 sequence for seed 7F:
        // bytes 70 4F 93 40 | 64 74 6D 30 | 2B E7 ..., data XORed in.
        vt[0] = '{0, 4, 32'h00000000, 1'b0, 32'h40934F70, 1'b0};
        vt[1] = '{0, 4, 32'hA50F00FF, 1'b0, 32'h9562749B, 1'b0};
        vt[2] = '{0, 2, 32'h00008001, 1'b1, 32'h0000672A, 1'b1};
        vt[3] = '{0, 1, 32'h000000FF, 1'b1, 32'h0000008F, 1'b1};
        vt[4] = '{0, 4, 32'h00000000, 1'b1, 32'h40934F70, 1'b1};
        vt[5] = '{1, 4, 32'h44332211, 1'b0, 32'h44332211, 1'b0};
        vt[6] = '{1, 2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 1'b1};
        vt[7] = '{0, 4, 32'h00000000, 1'b0, 32'h40934F70, 1'b0};

        // Reset state
        #12;
        chk("rst_m_tvalid", a_m_tvalid, 0);
        chk("rst_m_tdata", a_m_tdata, 0);
        chk("rst_m_tlast", a_m_tlast, 0);
        chk("rst_s_tready", a_s_tready, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #2;

        // Vector table
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < vt[v].n; k++) begin
                send(vt[v].sel, vt[v].din[8*k +: 8],
                     vt[v].last && (k == vt[v].n - 1));
            end
            chk($sformatf("v%0d_latency_valid", v),
                (vt[v].sel != 0) ? b_m_tvalid : a_m_tvalid, 1);
            @(negedge clk); #1;
            chk($sformatf("v%0d_word_count", v),
                (vt[v].sel != 0) ? qb.size() : qa.size(), 1);
            w = pop_word(vt[v].sel);
            chk($sformatf("v%0d_data", v), w[31:0], vt[v].exp_data);
            chk($sformatf("v%0d_last", v), w[32], vt[v].exp_last);
            @(posedge clk); #2;
        end

        // Backpressure: word held for 10 cycles, input stalled
        pulse_reset_mod();
        qa.delete();
        a_m_tready = 1'b0;
        for (int k = 0; k < 4; k++) send(0, 8'h00, 1'b0);
        held = a_m_tdata;
        a_s_tdata = 8'h00; a_s_tlast = 1'b0; a_s_tvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            chk("bp_s_tready_low", a_s_tready, 0);
            chk("bp_m_tdata_held", a_m_tdata, 32'h40934F70);
        end
        chk("bp_no_transfer", qa.size(), 0);
        @(posedge clk); #2;
        a_m_tready = 1'b1;
        @(negedge clk); #1;
        chk("bp_release_s_tready", a_s_tready, 1);
        @(posedge clk); #2;
        a_s_tvalid = 1'b0;
        chk("bp_taken_valid_low", a_m_tvalid, 0);
        chk("bp_one_word", qa.size(), 1);
        w = pop_word(0);
        chk("bp_word", w[31:0], held);

        // Mid-word reset_mod, with a byte offered during the clear
        pulse_reset_mod();
        qa.delete();
        send(0, 8'hFF, 1'b0);
        send(0, 8'hFF, 1'b0);
        a_s_tdata = 8'h55; a_s_tvalid = 1'b1;
        pulse_reset_mod();
        a_s_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) send(0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("rmod_one_word", qa.size(), 1);
        w = pop_word(0);
        chk("rmod_word", w[15:0], 16'h4F70);

        // Asynchronous rst drops a pending word immediately
        a_m_tready = 1'b0;
        for (int k = 0; k < 4; k++) send(0, 8'h00, 1'b0);
        @(negedge clk); #1;
        chk("arst_pending", a_m_tvalid, 1);
        rst = 1'b0;
        #1;
        chk("arst_valid_drop", a_m_tvalid, 0);
        chk("arst_data_clear", a_m_tdata, 0);
        chk("arst_s_tready", a_s_tready, 0);
        #1 rst = 1'b1;
        a_m_tready = 1'b1;
        @(posedge clk); #2;
        qa.delete();
        send(0, 8'hFF, 1'b0);
        send(0, 8'hFF, 1'b0);
        @(negedge clk); #1 rst = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #2;
        for (int k = 0; k < 4; k++) send(0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("arst_one_word", qa.size(), 1);
        w = pop_word(0);
        chk("arst_word", w[15:0], 16'h4F70);

        // 100-byte bypass stream under random backpressure
        qb.delete();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) send(1, 8'(i), i == 99);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #2;
                    b_m_tready = ($urandom_range(0, 3) != 0);
                end
                b_m_tready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #2;
        chk("stream_words", qb.size(), 25);
        for (int j = 0; j < 25; j++) begin
            logic [7:0] b0;
            b0 = 8'(4 * j);
            w = pop_word(1);
            chk($sformatf("stream_w%0d", j), w,
                {(j == 24), b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
